// File: rtl/multdiv_arbiter.sv
// Round-robin arbiter that shares one iterative multiply/divide unit between two requesters.
// It issues a one-cycle start pulse, waits for the unit's ready flag (with a watchdog), and routes the response back.
module multdiv_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        r0_valid,
    input  logic        r0_op,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    output logic        r0_ready,
    output logic        r0_resp,
    input  logic        r1_valid,
    input  logic        r1_op,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    output logic        r1_ready,
    output logic        r1_resp,
    output logic [31:0] resp_result,
    output logic        resp_exception,
    output logic        busy,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam int             CW      = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    state_t        state_q, state_d;
    logic          ptr_q, ptr_d;
    logic          owner_q, owner_d;
    logic          op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   res_q, res_d;
    logic          exc_q, exc_d;
    logic          gnt0, gnt1;

    // The pointer only matters when both ports contend.
    assign gnt1 = r1_valid & (~r0_valid | ptr_q);
    assign gnt0 = r0_valid & (~r1_valid | ~ptr_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        exc_d        = exc_q;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        r0_resp      = 1'b0;
        r1_resp      = 1'b0;
        md_ctrl_MULT = 1'b0;
        md_ctrl_DIV  = 1'b0;
        case (state_q)
            S_IDLE: begin
                r0_ready = gnt0;
                r1_ready = gnt1;
                if (gnt0 | gnt1) begin
                    owner_d = gnt1;
                    ptr_d   = ~gnt1;
                    op_d    = gnt1 ? r1_op : r0_op;
                    a_d     = gnt1 ? r1_a  : r0_a;
                    b_d     = gnt1 ? r1_b  : r0_b;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A ready flag here may be stale from the previous operation.
                md_ctrl_MULT = ~op_q;
                md_ctrl_DIV  = op_q;
                cnt_d        = '0;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (md_resultRDY) begin
                    res_d   = md_result;
                    exc_d   = md_exception;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_MAX) begin
                    res_d   = '0;
                    exc_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                r0_resp = ~owner_q;
                r1_resp = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy           = (state_q != S_IDLE);
    assign md_operandA    = a_q;
    assign md_operandB    = b_q;
    assign resp_result    = res_q;
    assign resp_exception = exc_q;

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Directed bench for multdiv_arbiter with a small behavioural multiply/divide unit.
// The unit answers LAT cycles after the pulse, or never when hang is set.
module tb_multdiv_arbiter;

    localparam int TMO = 8;
    localparam int LAT = 2;
    localparam int RESP_LAT = LAT + 2;   // resp distance from ISSUE for a normal op
    localparam int TMO_LAT  = TMO + 1;   // TMO wait cycles, then RESP

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        r0_valid = 1'b0, r0_op = 1'b0;
    logic [31:0] r0_a = '0, r0_b = '0;
    logic        r1_valid = 1'b0, r1_op = 1'b0;
    logic [31:0] r1_a = '0, r1_b = '0;
    logic        r0_ready, r0_resp, r1_ready, r1_resp;
    logic [31:0] resp_result;
    logic        resp_exception, busy;
    logic [31:0] md_operandA, md_operandB;
    logic        md_ctrl_MULT, md_ctrl_DIV;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0;
    logic        md_resultRDY = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    logic        hang = 1'b0;
    logic        force_rdy = 1'b0;
    int unsigned pulse_cnt = 0;
    int unsigned stale_until = 0;
    logic        pend = 1'b0;
    int          dly = 0;
    logic [31:0] mres = '0;
    logic        mexc = 1'b0;

    multdiv_arbiter #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .r0_valid(r0_valid), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r0_ready(r0_ready), .r0_resp(r0_resp),
        .r1_valid(r1_valid), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .r1_ready(r1_ready), .r1_resp(r1_resp),
        .resp_result(resp_result), .resp_exception(resp_exception), .busy(busy),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY)
    );

    always #5 clock = ~clock;

    // Unit model; divide by zero returns all ones with exception set.
    always @(posedge clock) begin
        if (reset) begin
            pend         <= 1'b0;
            md_resultRDY <= force_rdy;
        end else if (md_ctrl_MULT || md_ctrl_DIV) begin
            pulse_cnt    <= pulse_cnt + 1;
            pend         <= 1'b1;
            dly          <= LAT;
            md_resultRDY <= 1'b0;
            if (md_ctrl_DIV) begin
                mres <= (md_operandB == 0) ? 32'hFFFF_FFFF : md_operandA / md_operandB;
                mexc <= (md_operandB == 0);
            end else begin
                mres <= md_operandA * md_operandB;
                mexc <= 1'b0;
            end
        end else if (pend && !hang && dly == 1) begin
            md_resultRDY <= 1'b1;
            md_result    <= mres;
            md_exception <= mexc;
            pend         <= 1'b0;
        end else begin
            md_resultRDY <= force_rdy || (pulse_cnt < stale_until);
            if (pend && dly > 1) dly <= dly - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller drives the valids; the task waits for the grant, follows the op and checks the response.
    task automatic run_op(input string tag, input int port, input logic op,
                          input logic [31:0] a, input logic [31:0] b, input logic hold,
                          input logic [31:0] exp_res, input logic exp_exc, input int exp_lat);
        int n;
        int lat;
        logic stable;
        #1;
        n = 0;
        while (!(port == 1 ? r1_ready : r0_ready) && n < 20) begin
            @(negedge clock); #1; n++;
        end
        chk({tag, ".grant"}, {31'b0, (port == 1 ? r1_ready : r0_ready)}, 32'd1);
        chk({tag, ".other_rdy"}, {31'b0, (port == 1 ? r0_ready : r1_ready)}, 32'd0);
        @(negedge clock);
        if (!hold) begin r0_valid = 1'b0; r1_valid = 1'b0; end
        #1;
        chk({tag, ".start"}, {30'b0, md_ctrl_MULT, md_ctrl_DIV}, op ? 32'd1 : 32'd2);
        chk({tag, ".opA"}, md_operandA, a);
        chk({tag, ".opB"}, md_operandB, b);
        stable = 1'b1;
        lat = 0;
        do begin
            @(negedge clock); #1; lat++;
            if (md_operandA !== a || md_operandB !== b || md_ctrl_MULT || md_ctrl_DIV)
                stable = 1'b0;
        end while (!(r0_resp || r1_resp) && lat < 40);
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".stable"}, {31'b0, stable}, 32'd1);
        chk({tag, ".resp"}, {30'b0, r1_resp, r0_resp}, port == 1 ? 32'd2 : 32'd1);
        chk({tag, ".result"}, resp_result, exp_res);
        chk({tag, ".exc"}, {31'b0, resp_exception}, {31'b0, exp_exc});
    endtask

    initial begin
        int n;
        logic saw_resp, saw_busy;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        chk("rst.ctl", {26'b0, busy, r0_ready, r1_ready, r0_resp, r1_resp, md_ctrl_MULT}, 32'd0);
        chk("rst.div", {30'b0, md_ctrl_DIV, resp_exception}, 32'd0);
        chk("rst.result", resp_result, 32'd0);
        chk("rst.opA", md_operandA, 32'd0);
        @(negedge clock); reset = 1'b0;

        // 1: single multiply on port 0
        @(negedge clock);
        r0_valid = 1'b1; r0_op = 1'b0; r0_a = 32'd7; r0_b = 32'd6;
        run_op("t1", 0, 1'b0, 32'd7, 32'd6, 1'b0, 32'd42, 1'b0, RESP_LAT);

        // 2: single divide on port 1
        @(negedge clock);
        r1_valid = 1'b1; r1_op = 1'b1; r1_a = 32'd101; r1_b = 32'd3;
        run_op("t2", 1, 1'b1, 32'd101, 32'd3, 1'b0, 32'd33, 1'b0, RESP_LAT);

        // 3: both held valid, grants alternate starting at port 0
        @(negedge clock);
        r0_valid = 1'b1; r0_op = 1'b0; r0_a = 32'd5;   r0_b = 32'd5;
        r1_valid = 1'b1; r1_op = 1'b1; r1_a = 32'd100; r1_b = 32'd10;
        run_op("t3a", 0, 1'b0, 32'd5,   32'd5,  1'b1, 32'd25, 1'b0, RESP_LAT);
        run_op("t3b", 1, 1'b1, 32'd100, 32'd10, 1'b1, 32'd10, 1'b0, RESP_LAT);
        run_op("t3c", 0, 1'b0, 32'd5,   32'd5,  1'b1, 32'd25, 1'b0, RESP_LAT);
        run_op("t3d", 1, 1'b1, 32'd100, 32'd10, 1'b0, 32'd10, 1'b0, RESP_LAT);

        // 4: hung unit triggers the watchdog, then normal traffic resumes
        @(negedge clock);
        hang = 1'b1;
        r1_valid = 1'b1; r1_op = 1'b0; r1_a = 32'd2; r1_b = 32'd3;
        run_op("t4", 1, 1'b0, 32'd2, 32'd3, 1'b0, 32'd0, 1'b1, TMO_LAT);
        @(negedge clock);
        hang = 1'b0;
        r0_valid = 1'b1; r0_op = 1'b0; r0_a = 32'd7; r0_b = 32'd6;
        run_op("t4r", 0, 1'b0, 32'd7, 32'd6, 1'b0, 32'd42, 1'b0, RESP_LAT);

        // 5: reset during WAIT abandons the op; a late ready flag is ignored
        @(negedge clock);
        hang = 1'b1;
        r0_valid = 1'b1; r0_op = 1'b0; r0_a = 32'd3; r0_b = 32'd4;
        #1;
        n = 0;
        while (!r0_ready && n < 20) begin @(negedge clock); #1; n++; end
        chk("t5.grant", {31'b0, r0_ready}, 32'd1);
        @(negedge clock); r0_valid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        chk("t5.in_wait", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        #1;
        chk("t5.ctl", {26'b0, busy, r0_ready, r1_ready, r0_resp, r1_resp, md_ctrl_MULT}, 32'd0);
        chk("t5.div", {30'b0, md_ctrl_DIV, resp_exception}, 32'd0);
        chk("t5.result", resp_result, 32'd0);
        chk("t5.opA", md_operandA, 32'd0);
        hang = 1'b0;
        saw_resp = 1'b0; saw_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            force_rdy = (i == 1);
            #1;
            if (r0_resp || r1_resp) saw_resp = 1'b1;
            if (busy) saw_busy = 1'b1;
        end
        force_rdy = 1'b0;
        chk("t5.no_resp", {31'b0, saw_resp}, 32'd0);
        chk("t5.idle", {31'b0, saw_busy}, 32'd0);
        // Pointer must be back at port 0 after reset
        @(negedge clock);
        r0_valid = 1'b1; r0_op = 1'b0; r0_a = 32'd3;   r0_b = 32'd4;
        r1_valid = 1'b1; r1_op = 1'b1; r1_a = 32'd100; r1_b = 32'd10;
        run_op("t5r", 0, 1'b0, 32'd3, 32'd4, 1'b0, 32'd12, 1'b0, RESP_LAT);

        // 6: divide by zero with a stale ready flag present during ISSUE
        @(negedge clock);
        stale_until = pulse_cnt + 1;
        r1_valid = 1'b1; r1_op = 1'b1; r1_a = 32'd9; r1_b = 32'd0;
        run_op("t6", 1, 1'b1, 32'd9, 32'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, RESP_LAT);

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
